// File: rtl/br_resolver.sv
// ---------------------------------------------------------------------------
// br_resolver
//
// This block resolves conditional branches. It keeps a small shadow copy of
// the fetch-time branch prediction for the instructions in ID and EX. When
// EX reports the real branch outcome, the block:
//   - tells the predictor to update (exactly once per branch), and
//   - on a mispredict, raises a one-cycle flush and a corrected fetch PC.
//
// Optional feature: define the macro BR_STATS_EN to add saturating
// resolved-branch and mispredict counters (br_cnt / miss_cnt ports).
//
// Ports:
//   cpu_clk         in   1   core clock
//   cpu_rst         in   1   asynchronous active-high reset
//   if_valid        in   1   IF holds a valid instruction
//   if_is_B         in   1   IF instruction predecoded as conditional branch
//   if_pre_br       in   1   predictor output sampled in IF (1 = taken)
//   if_pc           in  32   PC of the IF instruction
//   pipe_stall      in   1   hold IF/ID and ID/EX this cycle
//   ex_is_B         in   1   EX decoded a conditional branch
//   ex_real_br      in   1   EX branch outcome (1 = taken)
//   ex_br_target    in  32   EX computed branch target
//   is_B            out  1   predictor update enable
//   real_br         out  1   predictor update outcome
//   flush           out  1   one-cycle pulse: squash IF/ID and ID/EX
//   redirect_valid  out  1   redirect_pc is valid (same as flush)
//   redirect_pc     out 32   corrected fetch PC
//   br_cnt          out 32   resolved-branch count   (BR_STATS_EN only)
//   miss_cnt        out 32   mispredict count        (BR_STATS_EN only)
// ---------------------------------------------------------------------------
module br_resolver (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        if_valid,
    input  logic        if_is_B,
    input  logic        if_pre_br,
    input  logic [31:0] if_pc,
    input  logic        pipe_stall,
    input  logic        ex_is_B,
    input  logic        ex_real_br,
    input  logic [31:0] ex_br_target,
    output logic        is_B,
    output logic        real_br,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef BR_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
`endif
);

    typedef struct packed {
        logic        valid;
        logic        is_b;
        logic        pre_br;
        logic [31:0] pc;
    } slot_t;

    slot_t s_id;
    slot_t s_ex;

    logic pred;
    logic resolve;
    logic mispredict;

    // A non-branch in IF never looks "taken" from the predictor's side, so
    // the prediction is masked by the fetch-time predecode bit.
    assign pred = s_ex.is_b & s_ex.pre_br;

    // A branch only resolves when it is really in EX (valid shadow slot) and
    // the pipeline is moving; while stalled, EX will present the same branch
    // again, so resolving now would update the predictor twice.
    assign resolve    = s_ex.valid & ex_is_B & ~pipe_stall;
    assign mispredict = resolve & (ex_real_br != pred);

    assign is_B           = resolve;
    assign real_br        = ex_real_br;
    assign redirect_valid = flush;

    // Shadow slots track the pipeline registers. A mispredict squashes both
    // younger instructions; otherwise they advance unless the pipe stalls.
    // During the flush cycle itself the slots load normally, picking up the
    // redirected fetch.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            s_id <= '0;
            s_ex <= '0;
        end else if (mispredict) begin
            s_id.valid <= 1'b0;
            s_ex.valid <= 1'b0;
        end else if (!pipe_stall) begin
            s_ex <= s_id;
            s_id <= '{valid: if_valid, is_b: if_is_B, pre_br: if_pre_br, pc: if_pc};
        end
    end

    // Flush pulse and corrected PC are captured on the mispredict edge.
    // redirect_pc keeps its last value between flushes. The not-taken fall
    // through address wraps naturally in 32-bit arithmetic.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= ex_real_br ? ex_br_target : (s_ex.pc + 32'd4);
            end
        end
    end

`ifdef BR_STATS_EN
    // Statistics counters saturate instead of wrapping so long runs never
    // report a misleadingly small count.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (resolve && (br_cnt != 32'hFFFF_FFFF)) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (mispredict && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_resolver.sv
// ---------------------------------------------------------------------------
// tb_br_resolver
//
// Directed bench for br_resolver. Each scenario task walks a branch through
// IF -> ID -> EX by hand and compares outputs against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// more unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_br_resolver;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        if_valid;
    logic        if_is_B;
    logic        if_pre_br;
    logic [31:0] if_pc;
    logic        pipe_stall;
    logic        ex_is_B;
    logic        ex_real_br;
    logic [31:0] ex_br_target;
    logic        is_B;
    logic        real_br;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    br_resolver dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .if_valid       (if_valid),
        .if_is_B        (if_is_B),
        .if_pre_br      (if_pre_br),
        .if_pc          (if_pc),
        .pipe_stall     (pipe_stall),
        .ex_is_B        (ex_is_B),
        .ex_real_br     (ex_real_br),
        .ex_br_target   (ex_br_target),
        .is_B           (is_B),
        .real_br        (real_br),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BR_STATS_EN
        ,
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_if(input logic v, input logic b, input logic p, input logic [31:0] pc);
        if_valid  = v;
        if_is_B   = b;
        if_pre_br = p;
        if_pc     = pc;
    endtask

    task automatic set_ex(input logic b, input logic r, input logic [31:0] tgt);
        ex_is_B      = b;
        ex_real_br   = r;
        ex_br_target = tgt;
    endtask

    // Loads a branch into IF, then advances it to EX with IF idle.
    task automatic load_branch(input logic pre, input logic [31:0] pc);
        set_if(1'b1, 1'b1, pre, pc);
        tick();
        set_if(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        cpu_rst    = 1'b1;
        pipe_stall = 1'b0;
        set_if(1'b0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b1, 1'b1, 32'h1234);
        tick();
        tick();
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush: got %0b want 0", flush); end
        total++;
        if (redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rv: got %0b want 0", redirect_valid); end
        total++;
        if (redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc: got %h want 0", redirect_pc); end
        total++;
        if (is_B !== 1'b0) begin bad++; $display("[TB] FAIL rst_isB: got %0b want 0", is_B); end
`ifdef BR_STATS_EN
        total++;
        if (br_cnt !== 32'h0) begin bad++; $display("[TB] FAIL rst_brcnt: got %h want 0", br_cnt); end
        total++;
        if (miss_cnt !== 32'h0) begin bad++; $display("[TB] FAIL rst_misscnt: got %h want 0", miss_cnt); end
`endif
        set_ex(1'b0, 1'b0, 32'h0);
        #2;
        cpu_rst = 1'b0;
        tick();
    endtask

    task automatic test_taken_mispredict();
        load_branch(1'b0, 32'h0000_0100);
        set_ex(1'b1, 1'b1, 32'h0000_0200);
        #1;
        total++;
        if (is_B !== 1'b1) begin bad++; $display("[TB] FAIL tm_isB: got %0b want 1", is_B); end
        total++;
        if (real_br !== 1'b1) begin bad++; $display("[TB] FAIL tm_realbr: got %0b want 1", real_br); end
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL tm_preflush: got %0b want 0", flush); end
        tick();
        total++;
        if (flush !== 1'b1) begin bad++; $display("[TB] FAIL tm_flush: got %0b want 1", flush); end
        total++;
        if (redirect_valid !== 1'b1) begin bad++; $display("[TB] FAIL tm_rv: got %0b want 1", redirect_valid); end
        total++;
        if (redirect_pc !== 32'h0000_0200) begin bad++; $display("[TB] FAIL tm_pc: got %h want 00000200", redirect_pc); end
        // EX still claims a branch, but the squashed slot must not resolve.
        total++;
        if (is_B !== 1'b0) begin bad++; $display("[TB] FAIL tm_squash: got %0b want 0", is_B); end
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL tm_pulse: got %0b want 0", flush); end
        total++;
        if (redirect_pc !== 32'h0000_0200) begin bad++; $display("[TB] FAIL tm_hold: got %h want 00000200", redirect_pc); end
    endtask

    task automatic test_nottaken_mispredict();
        load_branch(1'b1, 32'h0000_01FC);
        set_ex(1'b1, 1'b0, 32'h0000_0999);
        #1;
        total++;
        if (is_B !== 1'b1) begin bad++; $display("[TB] FAIL nt_isB: got %0b want 1", is_B); end
        tick();
        total++;
        if (flush !== 1'b1) begin bad++; $display("[TB] FAIL nt_flush: got %0b want 1", flush); end
        total++;
        if (redirect_pc !== 32'h0000_0200) begin bad++; $display("[TB] FAIL nt_pc: got %h want 00000200", redirect_pc); end
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_correct_prediction();
        load_branch(1'b1, 32'h0000_0300);
        set_ex(1'b1, 1'b1, 32'h0000_0400);
        #1;
        total++;
        if (is_B !== 1'b1) begin bad++; $display("[TB] FAIL ok_isB: got %0b want 1", is_B); end
        tick();
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL ok_flush: got %0b want 0", flush); end
        total++;
        if (redirect_pc !== 32'h0000_0200) begin bad++; $display("[TB] FAIL ok_pc: got %h want 00000200", redirect_pc); end
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_predecode_cases();
        // Predecode says branch, EX disagrees: no update, no flush.
        load_branch(1'b1, 32'h0000_0500);
        set_ex(1'b0, 1'b0, 32'h0000_0600);
        #1;
        total++;
        if (is_B !== 1'b0) begin bad++; $display("[TB] FAIL pd_isB: got %0b want 0", is_B); end
        tick();
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL pd_flush: got %0b want 0", flush); end
        // Not predecoded as branch but predictor said taken: counts as
        // not-taken, so a not-taken EX branch is correctly predicted.
        set_if(1'b1, 1'b0, 1'b1, 32'h0000_0700);
        tick();
        set_if(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_ex(1'b1, 1'b0, 32'h0000_0800);
        #1;
        total++;
        if (is_B !== 1'b1) begin bad++; $display("[TB] FAIL nb_isB: got %0b want 1", is_B); end
        tick();
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL nb_flush: got %0b want 0", flush); end
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_stall();
        load_branch(1'b0, 32'h0000_0A00);
        pipe_stall = 1'b1;
        set_ex(1'b1, 1'b1, 32'h0000_0B00);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (is_B !== 1'b0) begin bad++; $display("[TB] FAIL st_isB%0d: got %0b want 0", i, is_B); end
            tick();
            total++;
            if (flush !== 1'b0) begin bad++; $display("[TB] FAIL st_flush%0d: got %0b want 0", i, flush); end
        end
        pipe_stall = 1'b0;
        #1;
        total++;
        if (is_B !== 1'b1) begin bad++; $display("[TB] FAIL st_release: got %0b want 1", is_B); end
        tick();
        total++;
        if (flush !== 1'b1) begin bad++; $display("[TB] FAIL st_flush: got %0b want 1", flush); end
        total++;
        if (redirect_pc !== 32'h0000_0B00) begin bad++; $display("[TB] FAIL st_pc: got %h want 00000b00", redirect_pc); end
        total++;
        if (is_B !== 1'b0) begin bad++; $display("[TB] FAIL st_once: got %0b want 0", is_B); end
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        // Two branches in flight; the older mispredicts and squashes the younger.
        set_if(1'b1, 1'b1, 1'b0, 32'h0000_0C00);
        tick();
        set_if(1'b1, 1'b1, 1'b0, 32'h0000_0C04);
        tick();
        set_if(1'b0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b1, 1'b1, 32'h0000_0D00);
        #1;
        total++;
        if (is_B !== 1'b1) begin bad++; $display("[TB] FAIL bb_isB: got %0b want 1", is_B); end
        tick();
        total++;
        if (flush !== 1'b1) begin bad++; $display("[TB] FAIL bb_flush: got %0b want 1", flush); end
        set_ex(1'b1, 1'b1, 32'h0000_0E00);
        #1;
        total++;
        if (is_B !== 1'b0) begin bad++; $display("[TB] FAIL bb_young: got %0b want 0", is_B); end
        tick();
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL bb_noflush: got %0b want 0", flush); end
        total++;
        if (redirect_pc !== 32'h0000_0D00) begin bad++; $display("[TB] FAIL bb_pc: got %h want 00000d00", redirect_pc); end
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_wrap_reset();
        load_branch(1'b1, 32'hFFFF_FFFC);
        set_ex(1'b1, 1'b0, 32'h0000_1234);
        tick();
        total++;
        if (flush !== 1'b1) begin bad++; $display("[TB] FAIL wr_flush: got %0b want 1", flush); end
        total++;
        if (redirect_pc !== 32'h0000_0000) begin bad++; $display("[TB] FAIL wr_pc: got %h want 00000000", redirect_pc); end
        set_ex(1'b0, 1'b0, 32'h0);
        cpu_rst = 1'b1;
        #1;
        total++;
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL wr_abort: got %0b want 0", flush); end
        total++;
        if (redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_rv: got %0b want 0", redirect_valid); end
        tick();
        #2;
        cpu_rst = 1'b0;
        tick();
    endtask

`ifdef BR_STATS_EN
    task automatic test_stats();
        logic [4:0] pre_v  = 5'b10101;
        logic [4:0] real_v = 5'b10011;
        cpu_rst = 1'b1;
        #2;
        cpu_rst = 1'b0;
        tick();
        // Branches 1 and 2 (pre != real) mispredict; 0, 3, 4 are correct.
        for (int i = 0; i < 5; i++) begin
            load_branch(pre_v[i], 32'h0000_2000 + 32'(i * 16));
            set_ex(1'b1, real_v[i], 32'h0000_3000);
            tick();
            set_ex(1'b0, 1'b0, 32'h0);
            tick();
        end
        total++;
        if (br_cnt !== 32'd5) begin bad++; $display("[TB] FAIL st_brcnt: got %0d want 5", br_cnt); end
        total++;
        if (miss_cnt !== 32'd2) begin bad++; $display("[TB] FAIL st_misscnt: got %0d want 2", miss_cnt); end
        force dut.br_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt;
        load_branch(1'b1, 32'h0000_4000);
        set_ex(1'b1, 1'b1, 32'h0000_5000);
        tick();
        set_ex(1'b0, 1'b0, 32'h0);
        total++;
        if (br_cnt !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL st_sat: got %h want ffffffff", br_cnt); end
    endtask
`endif

    initial begin
        $display("[TB] starting br_resolver bench");
        test_reset();
        test_taken_mispredict();
        test_nottaken_mispredict();
        test_correct_prediction();
        test_predecode_cases();
        test_stall();
        test_back_to_back();
        test_wrap_reset();
`ifdef BR_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_resolver.md
BR_RESOLVER -- requirements
Module: br_resolver

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock port is cpu_clk, and the reset port is cpu_rst, asynchronous and active-high.
REQ-002 The ports SHALL be, one per line: name  direction  width  meaning.
  cpu_clk  in  1  core clock
  cpu_rst  in  1  asynchronous active-high reset
  if_valid  in  1  IF holds a valid instruction
  if_is_B  in  1  IF instruction predecoded as conditional branch
  if_pre_br  in  1  predictor output sampled in IF (1 = taken)
  if_pc  in  32  PC of IF instruction
  pipe_stall  in  1  hold IF/ID and ID/EX this cycle
  ex_is_B  in  1  EX decoded conditional branch
  ex_real_br  in  1  EX branch outcome (1 = taken)
  ex_br_target  in  32  EX computed branch target
  is_B  out  1  predictor update enable
  real_br  out  1  predictor update outcome
  flush  out  1  one-cycle pulse: squash IF/ID and ID/EX
  redirect_valid  out  1  redirect_pc is valid (equals flush)
  redirect_pc  out  32  corrected fetch PC
  br_cnt  out  32  resolved-branch count (BR_STATS_EN only)
  miss_cnt  out  32  mispredict count (BR_STATS_EN only)

Function
REQ-003 The block SHALL hold two shadow slots, S_ID and S_EX, each storing {valid, is_B, pre_br, pc[31:0]}.
REQ-004 On each rising edge with pipe_stall=0 and no flush: S_EX <= S_ID, and S_ID <= {if_valid, if_is_B, if_pre_br, if_pc}.
REQ-005 On each rising edge with pipe_stall=1 and no flush, both slots SHALL hold their contents.
REQ-006 The prediction SHALL be pred = S_EX.is_B & S_EX.pre_br; a non-branch in IF counts as predicted not-taken.
REQ-007 resolve SHALL be defined as S_EX.valid & ex_is_B & ~pipe_stall.
REQ-008 is_B SHALL equal resolve and real_br SHALL equal ex_real_br, both combinational, so the predictor updates exactly once per branch.
REQ-009 mispredict SHALL be defined as resolve & (ex_real_br != pred).
REQ-010 When mispredict is 1 at an edge, flush and redirect_valid SHALL be 1 for exactly the next cycle.
REQ-011 redirect_pc SHALL be registered at the same edge: ex_br_target if ex_real_br=1, otherwise S_EX.pc + 4 (modulo 2^32 wrap).
REQ-012 At the edge where mispredict=1, both slots SHALL be cleared to valid=0.
REQ-013 During the flush cycle, slot loading SHALL follow REQ-004/REQ-005 (refill with the redirected fetch).
REQ-014 An invalidated S_EX SHALL never produce resolve, so back-to-back flushes from squashed instructions are impossible.
REQ-015 If ex_is_B=0 while S_EX.is_B=1 (predecode disagreement), there is no update and no flush.
REQ-016 While flush=0, redirect_pc SHALL hold its last value.

Reset
REQ-017 While cpu_rst=1, both slots SHALL be valid=0, and flush, redirect_valid, redirect_pc, br_cnt and miss_cnt SHALL all be 0.
REQ-018 is_B SHALL be 0 while cpu_rst=1 (because S_EX.valid=0).
REQ-019 Reset asserted mid-flush SHALL abort the pulse immediately.

Configuration
REQ-020 With macro BR_STATS_EN defined, br_cnt SHALL increment on each resolve and miss_cnt on each mispredict, both saturating at 32'hFFFFFFFF.
REQ-021 Without BR_STATS_EN, the br_cnt and miss_cnt ports and their logic SHALL be absent.

Verification
REQ-022 Taken branch predicted not-taken: if_pre_br=0, pc=0x100; in EX ex_real_br=1, target=0x200 -> is_B=1 that cycle; next cycle flush=1, redirect_pc=0x200; slots invalid.
REQ-023 Not-taken branch predicted taken: pc=0x1FC, ex_real_br=0 -> flush=1 next cycle, redirect_pc=0x200.
REQ-024 Correct prediction: if_pre_br=1, ex_real_br=1 -> is_B=1, flush stays 0, redirect_pc unchanged.
REQ-025 Stall: pipe_stall=1 for 3 cycles with a mispredicting branch in EX -> is_B=0 and no flush during the stall; single update and flush after the stall releases.
REQ-026 Wrap and reset: pc=0xFFFFFFFC, ex_real_br=0, predicted taken -> redirect_pc=0x00000000; cpu_rst asserted during the flush cycle -> flush=0 immediately.
REQ-027 BR_STATS_EN: 5 branches including 2 mispredicts -> br_cnt=5, miss_cnt=2; preload br_cnt=0xFFFFFFFF -> stays 0xFFFFFFFF.
